data_sel_router: RTL and testbench

- Registered request router between one master agent and NO_OF_SLAVES slave agents on the data_if bus.
- Captures a master request (data, one-hot sel, valid) and forwards it to the single selected slave.
- Waits for that slave's ready, then returns a one-cycle ready (or error) pulse to the master.
- Replaces the combinational routing in the testbench top with a clocked, timeout-protected stage. It is the block that feeds the slave agents.

---
 rtl/data_sel_router.sv | 121 ++++++++++++
 tb/tb_data_sel_router.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sel_router.sv
// Registered router between one master and NO_OF_SLAVES slaves. It forwards one
// one-hot request, waits for the slave's ready or a timeout, and then pulses m_ready/m_err.
module data_sel_router #(
  parameter int NO_OF_SLAVES = 2,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       m_data,
  input  logic [NO_OF_SLAVES-1:0] m_sel,
  input  logic                    m_valid,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [DATA_W-1:0]       s_data,
  output logic [NO_OF_SLAVES-1:0] s_sel,
  output logic [NO_OF_SLAVES-1:0] s_valid,
  input  logic [NO_OF_SLAVES-1:0] s_ready,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_VAL = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [NO_OF_SLAVES-1:0] sel_q, sel_d;
  logic                    err_q, err_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic                    m_ready_q, m_ready_d;
  logic                    m_err_q, m_err_d;
  logic [NO_OF_SLAVES-1:0] s_valid_q, s_valid_d;

  logic                    req_onehot;
  logic                    sel_hit;
  logic [WCNT_W-1:0]       wcnt_inc;

  assign req_onehot = (m_sel != '0) && ((m_sel & (m_sel - 1'b1)) == '0);
  // Only the addressed slave's ready counts, so a stray ready elsewhere cannot complete the transfer.
  assign sel_hit    = |(s_ready & sel_q);
  assign wcnt_inc   = wcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
      err_cnt_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      s_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
      err_cnt_q <= err_cnt_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      s_valid_q <= s_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (m_valid) begin
          data_d  = m_data;
          sel_d   = m_sel;
          err_d   = ~req_onehot;
          state_d = req_onehot ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        wcnt_d = wcnt_inc;
        if (sel_hit) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wcnt_inc == TO_VAL) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = DRAIN;
      DRAIN:   if (!m_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side outputs follow the next state, so s_valid is high exactly while the FSM is in ACCESS.
  // Master response is one flop behind RESP, which gives the two-cycle minimum latency.
  always_comb begin
    s_valid_d = (state_d == ACCESS) ? sel_d : '0;
    m_ready_d = (state_q == RESP);
    m_err_d   = (state_q == RESP) && err_q;
    err_cnt_d = err_cnt_q;
    if (state_q == RESP && err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign s_data  = data_q;
  assign s_sel   = s_valid_q;
  assign s_valid = s_valid_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_data_sel_router.sv
// Directed bench for data_sel_router. Expected responses, with their error bit and
// completion cycle, are queued as each request is driven and are checked when m_ready pulses.
module tb_data_sel_router;
  localparam int NS = 2, DW = 8, TO = 16, CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] m_data;
  logic [NS-1:0] m_sel;
  logic          m_valid;
  logic          m_ready, m_err;
  logic [DW-1:0] s_data;
  logic [NS-1:0] s_sel, s_valid, s_ready;
  logic [CW-1:0] err_cnt;

  data_sel_router #(.NO_OF_SLAVES(NS), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .m_data(m_data), .m_sel(m_sel), .m_valid(m_valid),
    .m_ready(m_ready), .m_err(m_err), .s_data(s_data), .s_sel(s_sel),
    .s_valid(s_valid), .s_ready(s_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic err; int at;} exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int passed = 0, total = 0, fails = 0;
  int sv_cycles = 0, s1_hits = 0, err_wo_rdy = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(string tag);
    int b = 0;
    while (sbq.size() != 0 && b < 60) begin
      step();
      b++;
    end
    chk({tag, "_done"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic release_master();
    m_valid = 1'b0;
    step(2);
  endtask

  task automatic drive(logic [NS-1:0] sel, logic [DW-1:0] data);
    m_sel   = sel;
    m_data  = data;
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: every m_ready pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (s_valid !== '0) sv_cycles++;
    if (s_valid[1] === 1'b1) s1_hits++;
    if (m_ready === 1'b0 && m_err !== 1'b0) err_wo_rdy++;
    if (m_ready === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("m_err", 32'(m_err), 32'(e.err));
        chk("ready_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_data = '0; m_sel = '0; m_valid = 1'b0; s_ready = '0;
    step(3);
    @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_err",   32'(m_err),   32'd0);
    chk("rst_s_sel",   32'(s_sel),   32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_data",  32'(s_data),  32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sv_cycles = 0;
    step(5);
    chk("idle_no_valid", 32'(sv_cycles), 32'd0);

    // Slave 0 answers one cycle after it sees s_valid
    s1_hits = 0;
    drive(2'b01, 8'hAB);
    step();
    @(negedge clk);
    chk("t2_s_sel",   32'(s_sel),   32'h1);
    chk("t2_s_valid", 32'(s_valid), 32'h1);
    chk("t2_s_data",  32'(s_data),  32'hAB);
    @(posedge clk); #1;
    s_ready = 2'b01;
    sbq.push_back('{1'b0, cyc + 2});
    step();
    s_ready = 2'b00;
    wait_done("t2");
    release_master();
    chk("t2_slave1_idle", 32'(s1_hits), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // Slave 1 is addressed, slave 0 holds a stray ready that must be ignored
    s_ready = 2'b01;
    drive(2'b10, 8'h5C);
    step();
    @(negedge clk);
    chk("t3_s_valid", 32'(s_valid), 32'h2);
    chk("t3_s_data",  32'(s_data),  32'h5C);
    @(posedge clk); #1;
    step(2);
    s_ready = 2'b11;
    sbq.push_back('{1'b0, cyc + 2});
    step();
    s_ready = 2'b00;
    wait_done("t3");
    release_master();

    // Timeout. Master inputs changing mid-access must not disturb the latched request.
    sv_cycles = 0;
    drive(2'b01, 8'h11);
    sbq.push_back('{1'b1, cyc + 1 + 17});
    step(4);
    m_data = 8'hFF;
    m_sel  = 2'b10;
    @(negedge clk);
    chk("t4_s_data_held",  32'(s_data),  32'h11);
    chk("t4_s_valid_held", 32'(s_valid), 32'h1);
    @(posedge clk); #1;
    wait_done("t4");
    chk("t4_valid_cycles", 32'(sv_cycles), 32'd16);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    release_master();

    // Invalid selects are refused without touching any slave. The master holds valid past ready.
    sv_cycles = 0;
    drive(2'b11, 8'h33);
    sbq.push_back('{1'b1, cyc + 2});
    wait_done("t5a");
    step(3);
    release_master();
    drive(2'b00, 8'h44);
    sbq.push_back('{1'b1, cyc + 2});
    wait_done("t5b");
    step(3);
    release_master();
    chk("t5_no_valid", 32'(sv_cycles), 32'd0);
    chk("t5_err_cnt", 32'(err_cnt), 32'd3);

    // Reset mid-access drops the transaction silently
    drive(2'b01, 8'h77);
    step(2);
    @(negedge clk);
    chk("t6_in_access", 32'(s_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    m_valid = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
    chk("t6_rst_m_ready", 32'(m_ready), 32'd0);
    chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    drive(2'b01, 8'h9D);
    step();
    @(negedge clk);
    chk("t6_s_data", 32'(s_data), 32'h9D);
    @(posedge clk); #1;
    s_ready = 2'b01;
    sbq.push_back('{1'b0, cyc + 2});
    step();
    s_ready = 2'b00;
    wait_done("t6");
    release_master();
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    chk("err_without_ready", 32'(err_wo_rdy), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
